// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions for the ECAP5-DPROC pipeline:
// opcodes, funct3 codes, ALU source selectors and the decode->execute bundle.
package ecap5_dproc_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_W    = 3'b010;
    localparam logic [2:0] FUNCT3_LBU  = 3'b100;
    localparam logic [2:0] FUNCT3_LHU  = 3'b101;
    localparam logic [2:0] FUNCT3_BR2  = 3'b010;
    localparam logic [2:0] FUNCT3_BR3  = 3'b011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_t;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_FOUR = 2'd2
    } src2_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [2:0]  alu_op;
        logic        alu_alt;
        src1_t       src1;
        src2_t       src2;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  reg_addr;
        logic        illegal;
    } id_ex_t;

endpackage

// File: rtl/decode_imm.sv
// Immediate extraction: selects the I/S/B/U/J layout from the opcode
// and sign-extends to 32 bits; formats without an immediate yield zero.
module decode_imm
    import ecap5_dproc_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u = {instr_i[31:12], 12'b0};
    assign w_imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        imm_o = 32'b0;
        case (instr_i[6:0])
            OPCODE_JALR,
            OPCODE_LOAD,
            OPCODE_OP_IMM: imm_o = w_imm_i;
            OPCODE_STORE:  imm_o = w_imm_s;
            OPCODE_BRANCH: imm_o = w_imm_b;
            OPCODE_LUI,
            OPCODE_AUIPC:  imm_o = w_imm_u;
            OPCODE_JAL:    imm_o = w_imm_j;
            default:       imm_o = 32'b0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: control decode, operand read and one pipeline register.
// Define DECODE_BYPASS_EN to forward same-cycle writeback data into rs1/rs2.
module decode
    import ecap5_dproc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  raddr1_o,
    input  logic [31:0] rdata1_i,
    output logic [4:0]  raddr2_o,
    input  logic [31:0] rdata2_i,
    input  logic        wb_write_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    output logic        output_valid_o,
    input  logic        output_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] rs1_val_o,
    output logic [31:0] rs2_val_o,
    output logic [31:0] imm_o,
    output logic [2:0]  alu_op_o,
    output logic        alu_alt_o,
    output logic [1:0]  alu_src1_o,
    output logic [1:0]  alu_src2_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic        jalr_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic        illegal_o
);

    logic        r_valid;
    id_ex_t      r_q;
    id_ex_t      w_d;
    logic        w_accept;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;
    logic [31:0] w_rs1;
    logic [31:0] w_rs2;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_rd     = instr_i[11:7];

    assign raddr1_o = instr_i[19:15];
    assign raddr2_o = instr_i[24:20];

    assign input_ready_o = !r_valid || output_ready_i;
    assign w_accept = input_valid_i && input_ready_o && !flush_i;

    decode_imm u_imm (
        .instr_i (instr_i),
        .imm_o   (w_imm)
    );

`ifdef DECODE_BYPASS_EN
    // Register file writes at the clock edge, so a same-cycle read is stale.
    assign w_rs1 = (wb_write_i && wb_waddr_i != 5'd0 && wb_waddr_i == raddr1_o)
                 ? wb_wdata_i : rdata1_i;
    assign w_rs2 = (wb_write_i && wb_waddr_i != 5'd0 && wb_waddr_i == raddr2_o)
                 ? wb_wdata_i : rdata2_i;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_write_i, wb_waddr_i, wb_wdata_i};
    assign w_rs1 = rdata1_i;
    assign w_rs2 = rdata2_i;
`endif

    always_comb begin
        w_d           = '0;
        w_d.pc        = pc_i;
        w_d.rs1_val   = w_rs1;
        w_d.rs2_val   = w_rs2;
        w_d.imm       = w_imm;
        w_d.alu_op    = w_funct3;
        w_d.src1      = SRC1_RS1;
        w_d.src2      = SRC2_RS2;
        w_d.reg_addr  = w_rd;
        case (w_opcode)
            OPCODE_LUI: begin
                w_d.alu_op    = FUNCT3_ADD;
                w_d.src1      = SRC1_ZERO;
                w_d.src2      = SRC2_IMM;
                w_d.reg_write = 1'b1;
            end
            OPCODE_AUIPC: begin
                w_d.alu_op    = FUNCT3_ADD;
                w_d.src1      = SRC1_PC;
                w_d.src2      = SRC2_IMM;
                w_d.reg_write = 1'b1;
            end
            OPCODE_JAL: begin
                w_d.alu_op    = FUNCT3_ADD;
                w_d.src1      = SRC1_PC;
                w_d.src2      = SRC2_FOUR;
                w_d.jump      = 1'b1;
                w_d.reg_write = 1'b1;
            end
            OPCODE_JALR: begin
                w_d.src1      = SRC1_PC;
                w_d.src2      = SRC2_FOUR;
                w_d.jump      = 1'b1;
                w_d.jalr      = 1'b1;
                w_d.reg_write = 1'b1;
                w_d.illegal   = (w_funct3 != FUNCT3_ADD);
            end
            OPCODE_BRANCH: begin
                w_d.branch  = 1'b1;
                w_d.illegal = (w_funct3 == FUNCT3_BR2) || (w_funct3 == FUNCT3_BR3);
            end
            OPCODE_LOAD: begin
                w_d.src2      = SRC2_IMM;
                w_d.mem_read  = 1'b1;
                w_d.reg_write = 1'b1;
                w_d.illegal   = !((w_funct3 <= FUNCT3_W) ||
                                  (w_funct3 == FUNCT3_LBU) ||
                                  (w_funct3 == FUNCT3_LHU));
            end
            OPCODE_STORE: begin
                w_d.src2      = SRC2_IMM;
                w_d.mem_write = 1'b1;
                w_d.illegal   = (w_funct3 > FUNCT3_W);
            end
            OPCODE_OP_IMM: begin
                w_d.src2      = SRC2_IMM;
                w_d.reg_write = 1'b1;
                if (w_funct3 == FUNCT3_SLL) begin
                    w_d.illegal = (w_funct7 != FUNCT7_BASE);
                end else if (w_funct3 == FUNCT3_SR) begin
                    w_d.alu_alt = w_funct7[5];
                    w_d.illegal = (w_funct7 != FUNCT7_BASE) && (w_funct7 != FUNCT7_ALT);
                end
            end
            OPCODE_OP: begin
                w_d.alu_alt   = w_funct7[5];
                w_d.reg_write = 1'b1;
                w_d.illegal   = !((w_funct7 == FUNCT7_BASE) ||
                                  (w_funct7 == FUNCT7_ALT &&
                                   (w_funct3 == FUNCT3_ADD || w_funct3 == FUNCT3_SR)));
            end
            default: w_d.illegal = 1'b1;
        endcase
        // An illegal instruction must not cause any architectural side effect.
        if (w_d.illegal) begin
            w_d.reg_write = 1'b0;
            w_d.mem_read  = 1'b0;
            w_d.mem_write = 1'b0;
            w_d.branch    = 1'b0;
            w_d.jump      = 1'b0;
            w_d.jalr      = 1'b0;
        end
        if (w_rd == 5'd0) begin
            w_d.reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_q     <= '0;
            r_q.pc  <= RESET_PC;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_q     <= w_d;
        end else if (output_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign output_valid_o = r_valid;
    assign pc_o           = r_q.pc;
    assign rs1_val_o      = r_q.rs1_val;
    assign rs2_val_o      = r_q.rs2_val;
    assign imm_o          = r_q.imm;
    assign alu_op_o       = r_q.alu_op;
    assign alu_alt_o      = r_q.alu_alt;
    assign alu_src1_o     = r_q.src1;
    assign alu_src2_o     = r_q.src2;
    assign branch_o       = r_q.branch;
    assign jump_o         = r_q.jump;
    assign jalr_o         = r_q.jalr;
    assign mem_read_o     = r_q.mem_read;
    assign mem_write_o    = r_q.mem_write;
    assign reg_write_o    = r_q.reg_write;
    assign reg_addr_o     = r_q.reg_addr;
    assign illegal_o      = r_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage.
// Expectations follow DECODE_BYPASS_EN when the bench is built with it.
module tb_decode;
    import ecap5_dproc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [4:0]  raddr1_o;
    logic [31:0] rdata1_i;
    logic [4:0]  raddr2_o;
    logic [31:0] rdata2_i;
    logic        wb_write_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        output_valid_o;
    logic        output_ready_i;
    logic [31:0] pc_o;
    logic [31:0] rs1_val_o;
    logic [31:0] rs2_val_o;
    logic [31:0] imm_o;
    logic [2:0]  alu_op_o;
    logic        alu_alt_o;
    logic [1:0]  alu_src1_o;
    logic [1:0]  alu_src2_o;
    logic        branch_o;
    logic        jump_o;
    logic        jalr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic        illegal_o;

    int errors = 0;
    int checks = 0;

    decode #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .input_valid_i  (input_valid_i),
        .input_ready_o  (input_ready_o),
        .instr_i        (instr_i),
        .pc_i           (pc_i),
        .raddr1_o       (raddr1_o),
        .rdata1_i       (rdata1_i),
        .raddr2_o       (raddr2_o),
        .rdata2_i       (rdata2_i),
        .wb_write_i     (wb_write_i),
        .wb_waddr_i     (wb_waddr_i),
        .wb_wdata_i     (wb_wdata_i),
        .output_valid_o (output_valid_o),
        .output_ready_i (output_ready_i),
        .pc_o           (pc_o),
        .rs1_val_o      (rs1_val_o),
        .rs2_val_o      (rs2_val_o),
        .imm_o          (imm_o),
        .alu_op_o       (alu_op_o),
        .alu_alt_o      (alu_alt_o),
        .alu_src1_o     (alu_src1_o),
        .alu_src2_o     (alu_src2_o),
        .branch_o       (branch_o),
        .jump_o         (jump_o),
        .jalr_o         (jalr_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .reg_write_o    (reg_write_o),
        .reg_addr_o     (reg_addr_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        input_valid_i = 1'b0;
        instr_i = 32'h0;
        pc_i = 32'h0;
        rdata1_i = 32'h0;
        rdata2_i = 32'h0;
        wb_write_i = 1'b0;
        wb_waddr_i = 5'd0;
        wb_wdata_i = 32'h0;
        output_ready_i = 1'b1;
        #12;
        chk("rst_valid", {31'b0, output_valid_o}, 32'd0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_ready", {31'b0, input_ready_o}, 32'd1);
        rst_i = 1'b0;

        // ADDI x1,x2,-5
        input_valid_i = 1'b1;
        instr_i = 32'hFFB10093;
        pc_i = 32'h100;
        rdata1_i = 32'h10;
        rdata2_i = 32'h99;
        #1;
        chk("addi_raddr1", {27'b0, raddr1_o}, 32'd2);
        step();
        chk("addi_valid", {31'b0, output_valid_o}, 32'd1);
        chk("addi_pc", pc_o, 32'h100);
        chk("addi_rs1", rs1_val_o, 32'h10);
        chk("addi_imm", imm_o, 32'hFFFFFFFB);
        chk("addi_rd", {27'b0, reg_addr_o}, 32'd1);
        chk("addi_we", {31'b0, reg_write_o}, 32'd1);
        chk("addi_src2", {30'b0, alu_src2_o}, {30'b0, SRC2_IMM});
        chk("addi_src1", {30'b0, alu_src1_o}, {30'b0, SRC1_RS1});

        // Stall two cycles with ADD x3,x1,x2 pending
        output_ready_i = 1'b0;
        instr_i = 32'h002081B3;
        pc_i = 32'h104;
        rdata1_i = 32'h11;
        rdata2_i = 32'h22;
        #1;
        chk("stall_in_ready", {31'b0, input_ready_o}, 32'd0);
        chk("stall_raddr2", {27'b0, raddr2_o}, 32'd2);
        step();
        chk("stall1_pc", pc_o, 32'h100);
        chk("stall1_imm", imm_o, 32'hFFFFFFFB);
        step();
        chk("stall2_valid", {31'b0, output_valid_o}, 32'd1);
        chk("stall2_pc", pc_o, 32'h100);
        chk("stall2_rs1", rs1_val_o, 32'h10);
        output_ready_i = 1'b1;
        #1;
        chk("unstall_in_ready", {31'b0, input_ready_o}, 32'd1);
        step();
        chk("add_pc", pc_o, 32'h104);
        chk("add_rs1", rs1_val_o, 32'h11);
        chk("add_rs2", rs2_val_o, 32'h22);
        chk("add_src2", {30'b0, alu_src2_o}, {30'b0, SRC2_RS2});
        chk("add_rd", {27'b0, reg_addr_o}, 32'd3);
        chk("add_alt", {31'b0, alu_alt_o}, 32'd0);

        // Flush drops SUB x5,x6,x7, then it is accepted once flush clears
        instr_i = 32'h407302B3;
        pc_i = 32'h108;
        flush_i = 1'b1;
        step();
        chk("flush_valid", {31'b0, output_valid_o}, 32'd0);
        flush_i = 1'b0;
        step();
        chk("sub_valid", {31'b0, output_valid_o}, 32'd1);
        chk("sub_pc", pc_o, 32'h108);
        chk("sub_alt", {31'b0, alu_alt_o}, 32'd1);
        chk("sub_rd", {27'b0, reg_addr_o}, 32'd5);

        // JAL x1,+8
        instr_i = 32'h008000EF;
        pc_i = 32'h200;
        step();
        chk("jal_imm", imm_o, 32'd8);
        chk("jal_jump", {31'b0, jump_o}, 32'd1);
        chk("jal_src1", {30'b0, alu_src1_o}, {30'b0, SRC1_PC});
        chk("jal_src2", {30'b0, alu_src2_o}, {30'b0, SRC2_FOUR});
        chk("jal_we", {31'b0, reg_write_o}, 32'd1);

        // SW x2,12(x1)
        instr_i = 32'h0020A623;
        pc_i = 32'h204;
        step();
        chk("sw_imm", imm_o, 32'd12);
        chk("sw_mw", {31'b0, mem_write_o}, 32'd1);
        chk("sw_we", {31'b0, reg_write_o}, 32'd0);
        chk("sw_op", {29'b0, alu_op_o}, 32'd2);

        // All-zero word is illegal
        instr_i = 32'h00000000;
        pc_i = 32'h208;
        step();
        chk("ill_flag", {31'b0, illegal_o}, 32'd1);
        chk("ill_we", {31'b0, reg_write_o}, 32'd0);
        chk("ill_mw", {31'b0, mem_write_o}, 32'd0);
        chk("ill_jump", {31'b0, jump_o}, 32'd0);

        // Writeback to x2 while reading x2
        instr_i = 32'hFFB10093;
        pc_i = 32'h20C;
        rdata1_i = 32'h10;
        wb_write_i = 1'b1;
        wb_waddr_i = 5'd2;
        wb_wdata_i = 32'hDEADBEEF;
        step();
`ifdef DECODE_BYPASS_EN
        chk("byp_rs1", rs1_val_o, 32'hDEADBEEF);
`else
        chk("byp_rs1", rs1_val_o, 32'h10);
`endif
        chk("byp_illegal", {31'b0, illegal_o}, 32'd0);

        // Writeback to x0 while reading x0 is never forwarded
        instr_i = 32'hFFB00093;
        rdata1_i = 32'h55;
        wb_waddr_i = 5'd0;
        step();
        chk("x0_rs1", rs1_val_o, 32'h55);
        wb_write_i = 1'b0;

        // Consumed with nothing new
        input_valid_i = 1'b0;
        step();
        chk("drain_valid", {31'b0, output_valid_o}, 32'd0);

        // Asynchronous reset during a stall
        input_valid_i = 1'b1;
        instr_i = 32'hFFB10093;
        pc_i = 32'h300;
        step();
        chk("pre_rst_valid", {31'b0, output_valid_o}, 32'd1);
        output_ready_i = 1'b0;
        input_valid_i = 1'b0;
        step();
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", {31'b0, output_valid_o}, 32'd0);
        chk("arst_pc", pc_o, 32'h0);
        chk("arst_imm", imm_o, 32'h0);
        chk("arst_rs1", rs1_val_o, 32'h0);
        chk("arst_we", {31'b0, reg_write_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
